bf16_mul_normalize: RTL and testbench
=====================================

# bf16_mul_normalize

Downstream stage of the BFLOAT16 exponent adder in the systolic-array PE multiply path. It multiplies the two 8-bit significands (hidden bit restored) and consumes the exponent adder's registered biased-exponent result and its overflow/underflow status one cycle later. It normalises, rounds to nearest-even, and saturates or flushes to produce a registered BFLOAT16 product. It is a 2-stage valid-only pipeline with no backpressure, plus sticky exception flags.

## Interface
- No parameters; fixed BFLOAT16 format (1/8/7).
- clk  in  1  rising-edge clock shared with the exponent adder
- clr  in  1  reset, asynchronous, active-high; clears all pipeline and status registers
- in_valid  in  1  operand-side valid for cycle t
- sign_a, sign_b  in  1 each  operand signs (cycle t)
- man_a, man_b  in  7 each  operand fractions, hidden 1 implied (cycle t)
- zero_a, zero_b  in  1 each  operand is ±0, i.e. exponent field 0 (cycle t)
- exp_in  in  8  biased exponent sum from exponent adder, valid in cycle t+1
- ovf_in, unf_in  in  1 each  exponent adder overflow/underflow status, valid in cycle t+1
- status_clr  in  1  synchronous clear of sticky flags
- out_valid  out  1  product valid
- product  out  16  BFLOAT16 result {sign, exp[7:0], frac[6:0]}
- ovf_out, unf_out  out  1 each  per-result exception, aligned with product
- ovf_sticky, unf_sticky  out  1 each  sticky exception flags

## Operation
- Stage 1, edge t+1:
  - Register in_valid, s = sign_a^sign_b, and z = zero_a|zero_b.
  - Register prod[15:0] = {1,man_a} * {1,man_b}.
  - Sample exp_in, ovf_in and unf_in into stage-1 registers.
- Stage 2, edge t+2: normalise, round, resolve exceptions, and register the outputs.
- Normalise:
  - If prod[15]=1: frac=prod[14:8], g=prod[7], st=|prod[6:0], inc=1.
  - Otherwise: frac=prod[13:7], g=prod[6], st=|prod[5:0], inc=0.
- Round to nearest-even:
  - Round up when g & (st | frac[0]).
  - If frac=0x7F rounds up, frac becomes 0x00 and inc increases by 1.
  - prod ≤ 0xFE01, so shift and round carry never both occur.
- Exponent: e9 = {1'b0,exp_in} + inc, 9-bit. e9 ≥ 0xFF is overflow.
- Exception priority, highest first:
  1. z: product = {s,15'b0}; ovf_out=unf_out=0.
  2. unf_in: product = {s,15'b0}; unf_out=1.
  3. ovf_in or e9 ≥ 0xFF: product = {s,8'hFE,7'h7F}, the maximum finite value; ovf_out=1.
  4. Otherwise: product = {s,e9[7:0],frac}.
- Sticky flags:
  - Set in stage 2 when out_valid is asserted with ovf_out or unf_out.
  - status_clr clears them on the next edge; a set in the same cycle wins over status_clr.
- Bubbles (in_valid=0) propagate as out_valid=0. product, ovf_out and unf_out hold their last values when out_valid=0.
- Fully pipelined: a new operand every cycle, throughput 1.

## Timing
- Reset values, async on clr: out_valid=0, product=16'h0000, ovf_out=0, unf_out=0, ovf_sticky=0, unf_sticky=0; stage-1 valid=0.
- Latency: in_valid high at edge t gives out_valid high at edge t+2.
- exp_in, ovf_in and unf_in are sampled at edge t+1, matching the exponent adder's one-register latency.
- Back-to-back operands produce back-to-back outputs with no gaps.
- clr mid-operation: all in-flight results are discarded. out_valid stays 0 until two edges after the first in_valid sampled following clr deassertion.
- Stage-1 and stage-2 registers for different operands never interact.

## Test plan
- 1.0×1.0: man 0/0, exp_in=0x7F -> product=0x3F80, out_valid exactly 2 cycles after in_valid.
- Normalise and sign:
  - 1.5×1.5 (man 0x40/0x40, exp_in=0x7F) -> 0x4010.
  - Same operands with sign_a=1 -> 0xC010.
- Round to nearest-even, exp_in=0x7F:
  - man 0x08/0x08 (tie, lsb even) -> 0x3F90.
  - man 0x18/0x08 (tie, lsb odd) -> 0x3FA2.
- Overflow:
  - ovf_in=1 -> 0x7F7F with ovf_out=1.
  - exp_in=0xFE with 1.5×1.5 -> 0x7F7F with ovf_out=1; ovf_sticky stays set until status_clr.
- Zero and underflow:
  - zero_a=1 with ovf_in=1 -> 0x0000 and no flags.
  - unf_in=1 with sign 1 -> 0x8000 and unf_out=1.
- Streaming and reset:
  - 10 back-to-back operands -> 10 consecutive correct outputs.
  - clr asserted mid-stream -> out_valid drops immediately and all outputs return to reset values.

Source files
------------

// File: rtl/bf16_mul_normalize.sv
// bf16_mul_normalize: significand multiply, normalise, RNE round and
// saturate/flush stage behind the BFLOAT16 exponent adder.
// Operands are captured on the edge where in_valid is sampled; the exponent
// adder's result for those operands arrives one cycle later and is captured
// alongside the significand product in stage 1; stage 2 registers the result.
module bf16_mul_normalize (
    input  logic        clk,
    input  logic        clr,
    input  logic        in_valid,
    input  logic        sign_a,
    input  logic        sign_b,
    input  logic [6:0]  man_a,
    input  logic [6:0]  man_b,
    input  logic        zero_a,
    input  logic        zero_b,
    input  logic [7:0]  exp_in,
    input  logic        ovf_in,
    input  logic        unf_in,
    input  logic        status_clr,
    output logic        out_valid,
    output logic [15:0] product,
    output logic        ovf_out,
    output logic        unf_out,
    output logic        ovf_sticky,
    output logic        unf_sticky
);

    // [0] operands captured, [1] stage 1 (product + exponent), [2] result
    logic [2:0]  vld_pipe_q, vld_pipe_d;

    logic        op_sign_q, op_sign_d;
    logic        op_zero_q, op_zero_d;
    logic [6:0]  op_man_a_q, op_man_a_d;
    logic [6:0]  op_man_b_q, op_man_b_d;

    logic        s1_sign_q, s1_sign_d;
    logic        s1_zero_q, s1_zero_d;
    logic [15:0] s1_prod_q, s1_prod_d;
    logic [7:0]  s1_exp_q, s1_exp_d;
    logic        s1_ovf_q, s1_ovf_d;
    logic        s1_unf_q, s1_unf_d;

    logic [15:0] product_q, product_d;
    logic        ovf_out_q, ovf_out_d;
    logic        unf_out_q, unf_out_d;
    logic        ovf_sticky_q, ovf_sticky_d;
    logic        unf_sticky_q, unf_sticky_d;

    // normalise / round intermediates
    logic        prod_top;
    logic [6:0]  frac_raw;
    logic        rnd_guard;
    logic        rnd_sticky;
    logic        round_up;
    logic [7:0]  frac_sum;
    logic [1:0]  inc;
    logic [8:0]  e9;
    logic        exp_ovf;

    // Valid shift and operand capture; operand regs only move on a real operand
    always_comb begin
        vld_pipe_d = {vld_pipe_q[1:0], in_valid};
        op_sign_d  = op_sign_q;
        op_zero_d  = op_zero_q;
        op_man_a_d = op_man_a_q;
        op_man_b_d = op_man_b_q;
        if (in_valid) begin
            op_sign_d  = sign_a ^ sign_b;
            op_zero_d  = zero_a | zero_b;
            op_man_a_d = man_a;
            op_man_b_d = man_b;
        end
    end

    // Stage 1: significand product plus the exponent adder's matching result
    always_comb begin
        s1_sign_d = s1_sign_q;
        s1_zero_d = s1_zero_q;
        s1_prod_d = s1_prod_q;
        s1_exp_d  = s1_exp_q;
        s1_ovf_d  = s1_ovf_q;
        s1_unf_d  = s1_unf_q;
        if (vld_pipe_q[0]) begin
            s1_sign_d = op_sign_q;
            s1_zero_d = op_zero_q;
            s1_prod_d = {1'b1, op_man_a_q} * {1'b1, op_man_b_q};
            s1_exp_d  = exp_in;
            s1_ovf_d  = ovf_in;
            s1_unf_d  = unf_in;
        end
    end

    // Normalise to 1.xxxxxxx and round to nearest-even
    always_comb begin
        prod_top = s1_prod_q[15];
        if (prod_top) begin
            frac_raw   = s1_prod_q[14:8];
            rnd_guard  = s1_prod_q[7];
            rnd_sticky = |s1_prod_q[6:0];
        end else begin
            frac_raw   = s1_prod_q[13:7];
            rnd_guard  = s1_prod_q[6];
            rnd_sticky = |s1_prod_q[5:0];
        end
        round_up = rnd_guard & (rnd_sticky | frac_raw[0]);
        // carry out of the fraction bumps the exponent; the product bound
        // keeps this from coinciding with the normalise shift
        frac_sum = {1'b0, frac_raw} + {7'b0, round_up};
        inc      = {1'b0, prod_top} + {1'b0, frac_sum[7]};
        e9       = {1'b0, s1_exp_q} + {7'b0, inc};
        exp_ovf  = (e9 >= 9'h0FF);
    end

    // Stage 2: exception priority, result hold on bubbles, sticky flags
    always_comb begin
        product_d = product_q;
        ovf_out_d = ovf_out_q;
        unf_out_d = unf_out_q;
        if (vld_pipe_q[1]) begin
            ovf_out_d = 1'b0;
            unf_out_d = 1'b0;
            if (s1_zero_q) begin
                product_d = {s1_sign_q, 15'b0};
            end else if (s1_unf_q) begin
                product_d = {s1_sign_q, 15'b0};
                unf_out_d = 1'b1;
            end else if (s1_ovf_q || exp_ovf) begin
                product_d = {s1_sign_q, 8'hFE, 7'h7F};
                ovf_out_d = 1'b1;
            end else begin
                product_d = {s1_sign_q, e9[7:0], frac_sum[6:0]};
            end
        end
        // a new event on this edge beats a clear on the same edge
        ovf_sticky_d = (ovf_sticky_q & ~status_clr) | (vld_pipe_q[1] & ovf_out_d);
        unf_sticky_d = (unf_sticky_q & ~status_clr) | (vld_pipe_q[1] & unf_out_d);
    end

    // All pipeline and status state, cleared asynchronously
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            vld_pipe_q   <= '0;
            op_sign_q    <= 1'b0;
            op_zero_q    <= 1'b0;
            op_man_a_q   <= '0;
            op_man_b_q   <= '0;
            s1_sign_q    <= 1'b0;
            s1_zero_q    <= 1'b0;
            s1_prod_q    <= '0;
            s1_exp_q     <= '0;
            s1_ovf_q     <= 1'b0;
            s1_unf_q     <= 1'b0;
            product_q    <= '0;
            ovf_out_q    <= 1'b0;
            unf_out_q    <= 1'b0;
            ovf_sticky_q <= 1'b0;
            unf_sticky_q <= 1'b0;
        end else begin
            vld_pipe_q   <= vld_pipe_d;
            op_sign_q    <= op_sign_d;
            op_zero_q    <= op_zero_d;
            op_man_a_q   <= op_man_a_d;
            op_man_b_q   <= op_man_b_d;
            s1_sign_q    <= s1_sign_d;
            s1_zero_q    <= s1_zero_d;
            s1_prod_q    <= s1_prod_d;
            s1_exp_q     <= s1_exp_d;
            s1_ovf_q     <= s1_ovf_d;
            s1_unf_q     <= s1_unf_d;
            product_q    <= product_d;
            ovf_out_q    <= ovf_out_d;
            unf_out_q    <= unf_out_d;
            ovf_sticky_q <= ovf_sticky_d;
            unf_sticky_q <= unf_sticky_d;
        end
    end

    assign out_valid  = vld_pipe_q[2];
    assign product    = product_q;
    assign ovf_out    = ovf_out_q;
    assign unf_out    = unf_out_q;
    assign ovf_sticky = ovf_sticky_q;
    assign unf_sticky = unf_sticky_q;

endmodule

// File: tb/tb_bf16_mul_normalize.sv
// Bench for bf16_mul_normalize: directed and random operand streams checked
// against an integer reference of BF16 multiply with RNE and saturation.
module tb_bf16_mul_normalize;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        in_valid = 1'b0;
    logic        sign_a = 1'b0, sign_b = 1'b0;
    logic [6:0]  man_a = '0, man_b = '0;
    logic        zero_a = 1'b0, zero_b = 1'b0;
    logic [7:0]  exp_in = '0;
    logic        ovf_in = 1'b0, unf_in = 1'b0;
    logic        status_clr = 1'b0;
    logic        out_valid;
    logic [15:0] product;
    logic        ovf_out, unf_out, ovf_sticky, unf_sticky;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       sa, sb;
        logic [6:0] ma, mb;
        logic       za, zb;
        logic [7:0] e;
        logic       ov, un;
    } op_t;

    typedef struct packed {
        logic [15:0] p;
        logic        o, u;
    } res_t;

    op_t ops[$];
    bit  vld[$];

    // model state mirrored from the spec: last result and sticky flags
    logic [15:0] last_p;
    logic        last_o, last_u, m_ovf_st, m_unf_st;

    bf16_mul_normalize dut (
        .clk(clk), .clr(clr), .in_valid(in_valid),
        .sign_a(sign_a), .sign_b(sign_b), .man_a(man_a), .man_b(man_b),
        .zero_a(zero_a), .zero_b(zero_b), .exp_in(exp_in),
        .ovf_in(ovf_in), .unf_in(unf_in), .status_clr(status_clr),
        .out_valid(out_valid), .product(product), .ovf_out(ovf_out),
        .unf_out(unf_out), .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky)
    );

    always #5 clk = ~clk;

    // Reference: exact integer product, scaled to 8 significant bits with RNE
    function automatic res_t ref_mul(op_t o);
        res_t r;
        int p, sh, q, rem, half, e;
        logic s;
        s = o.sa ^ o.sb;
        r = '0;
        if (o.za || o.zb) begin
            r.p = {s, 15'b0};
        end else if (o.un) begin
            r.p = {s, 15'b0};
            r.u = 1'b1;
        end else begin
            p    = (128 + int'(o.ma)) * (128 + int'(o.mb));
            sh   = (p >= 32768) ? 8 : 7;
            q    = p >> sh;
            rem  = p - (q << sh);
            half = 1 << (sh - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q++;
            if (q == 256) begin q = 128; sh++; end
            e = int'(o.e) + sh - 7;
            if (o.ov || e >= 255) begin
                r.p = {s, 8'hFE, 7'h7F};
                r.o = 1'b1;
            end else begin
                r.p = {s, e[7:0], q[6:0]};
            end
        end
        return r;
    endfunction

    function automatic op_t mk(input bit sa, input bit sb, input bit [6:0] ma,
                               input bit [6:0] mb, input bit za, input bit zb,
                               input bit [7:0] e, input bit ov, input bit un);
        op_t o;
        o.sa = sa; o.sb = sb; o.ma = ma; o.mb = mb;
        o.za = za; o.zb = zb; o.e = e; o.ov = ov; o.un = un;
        return o;
    endfunction

    // Slot j: operands of op j, plus the exponent-adder result of op j-1
    task automatic drive_slot(input int j);
        op_t c, pv;
        c = '0;
        pv = '0;
        in_valid = 1'b0;
        if (j < ops.size()) begin c = ops[j]; in_valid = vld[j]; end
        if (j >= 1 && j - 1 < ops.size()) pv = ops[j-1];
        sign_a = c.sa; sign_b = c.sb; man_a = c.ma; man_b = c.mb;
        zero_a = c.za; zero_b = c.zb;
        exp_in = pv.e; ovf_in = pv.ov; unf_in = pv.un;
    endtask

    task automatic do_reset();
        ops.delete(); vld.delete();
        drive_slot(0);
        status_clr = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        last_p = '0; last_o = 1'b0; last_u = 1'b0;
        m_ovf_st = 1'b0; m_unf_st = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (product !== 16'h0000) begin errors++; $display("FAIL reset_product: got %h want 0000", product); end
        checks++; if ({ovf_out, unf_out, ovf_sticky, unf_sticky} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {ovf_out, unf_out, ovf_sticky, unf_sticky}); end
        in_valid = 1'b0;
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid: got %b want 0", out_valid); end
        end
    endtask

    task automatic test_directed();
        res_t r;
        int k;
        logic ev;
        do_reset();
        ops.push_back(mk(0,0,7'h00,7'h00,0,0,8'h7F,0,0)); // 1.0*1.0 -> 3F80
        ops.push_back(mk(0,0,7'h40,7'h40,0,0,8'h7F,0,0)); // 1.5*1.5 -> 4010
        ops.push_back(mk(1,0,7'h40,7'h40,0,0,8'h7F,0,0)); // -> C010
        ops.push_back(mk(0,0,7'h08,7'h08,0,0,8'h7F,0,0)); // tie, even -> 3F90
        ops.push_back(mk(0,0,7'h18,7'h08,0,0,8'h7F,0,0)); // tie, odd -> 3FA2
        ops.push_back(mk(0,0,7'h00,7'h00,0,0,8'h7F,1,0)); // ovf_in -> 7F7F
        ops.push_back(mk(0,0,7'h40,7'h40,0,0,8'hFE,0,0)); // shift overflow -> 7F7F
        ops.push_back(mk(0,0,7'h00,7'h00,1,0,8'h7F,1,0)); // zero beats ovf -> 0000
        ops.push_back(mk(1,0,7'h00,7'h00,0,0,8'h7F,0,1)); // unf -> 8000
        ops.push_back(mk(0,0,7'h35,7'h35,0,0,8'h7F,0,0)); // round carry -> 4000
        ops.push_back(mk(0,1,7'h00,7'h00,0,0,8'hFE,0,0)); // largest exp, no ovf -> FF00
        for (int i = 0; i < ops.size(); i++) vld.push_back(1'b1);
        for (int j = 0; j < ops.size() + 2; j++) begin
            drive_slot(j);
            @(negedge clk);
            k = j - 2;
            ev = 1'b0;
            if (k >= 0) begin
                ev = vld[k];
                if (vld[k]) begin
                    r = ref_mul(ops[k]);
                    last_p = r.p; last_o = r.o; last_u = r.u;
                    m_ovf_st |= r.o; m_unf_st |= r.u;
                end
            end
            checks++; if (out_valid !== ev) begin errors++; $display("FAIL dir_valid[%0d]: got %b want %b", j, out_valid, ev); end
            checks++; if (product !== last_p) begin errors++; $display("FAIL dir_product[%0d]: got %h want %h", j, product, last_p); end
            checks++; if ({ovf_out, unf_out} !== {last_o, last_u}) begin
                errors++; $display("FAIL dir_flags[%0d]: got %b want %b", j, {ovf_out, unf_out}, {last_o, last_u}); end
            checks++; if ({ovf_sticky, unf_sticky} !== {m_ovf_st, m_unf_st}) begin
                errors++; $display("FAIL dir_sticky[%0d]: got %b want %b", j, {ovf_sticky, unf_sticky}, {m_ovf_st, m_unf_st}); end
        end
    endtask

    task automatic test_sticky();
        // sticky flags were set by the directed stream and must still be held
        @(negedge clk);
        checks++; if ({ovf_sticky, unf_sticky} !== 2'b11) begin errors++; $display("FAIL sticky_hold: got %b want 11", {ovf_sticky, unf_sticky}); end
        status_clr = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
        checks++; if ({ovf_sticky, unf_sticky} !== 2'b00) begin errors++; $display("FAIL sticky_clear: got %b want 00", {ovf_sticky, unf_sticky}); end
        // overflow result lands on the same edge as status_clr: set wins
        ops.delete(); vld.delete();
        ops.push_back(mk(0,0,7'h00,7'h00,0,0,8'h80,1,0));
        vld.push_back(1'b1);
        drive_slot(0); @(negedge clk);
        drive_slot(1); @(negedge clk);
        drive_slot(2); status_clr = 1'b1; @(negedge clk);
        status_clr = 1'b0;
        checks++; if (out_valid !== 1'b1 || ovf_out !== 1'b1) begin errors++; $display("FAIL sticky_race_out: got %b%b want 11", out_valid, ovf_out); end
        checks++; if ({ovf_sticky, unf_sticky} !== 2'b10) begin errors++; $display("FAIL sticky_set_wins: got %b want 10", {ovf_sticky, unf_sticky}); end
        status_clr = 1'b1; @(negedge clk); status_clr = 1'b0;
        checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL sticky_clear2: got %b want 0", ovf_sticky); end
    endtask

    task automatic test_random();
        res_t r;
        int k;
        logic ev;
        op_t o;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            o.sa = 1'($urandom); o.sb = 1'($urandom);
            o.ma = 7'($urandom); o.mb = 7'($urandom);
            o.za = ($urandom_range(0, 15) == 0); o.zb = ($urandom_range(0, 15) == 0);
            o.e  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(8'hFB, 8'hFF)) : 8'($urandom_range(1, 8'hFA));
            o.ov = ($urandom_range(0, 19) == 0); o.un = ($urandom_range(0, 19) == 0);
            ops.push_back(o);
            vld.push_back($urandom_range(0, 4) != 0);
        end
        for (int j = 0; j < ops.size() + 2; j++) begin
            drive_slot(j);
            @(negedge clk);
            k = j - 2;
            ev = 1'b0;
            if (k >= 0) begin
                ev = vld[k];
                if (vld[k]) begin
                    r = ref_mul(ops[k]);
                    last_p = r.p; last_o = r.o; last_u = r.u;
                    m_ovf_st |= r.o; m_unf_st |= r.u;
                end
            end
            checks++; if (out_valid !== ev) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", j, out_valid, ev); end
            checks++; if (product !== last_p) begin errors++; $display("FAIL rnd_product[%0d]: got %h want %h", j, product, last_p); end
            checks++; if ({ovf_out, unf_out} !== {last_o, last_u}) begin
                errors++; $display("FAIL rnd_flags[%0d]: got %b want %b", j, {ovf_out, unf_out}, {last_o, last_u}); end
            checks++; if ({ovf_sticky, unf_sticky} !== {m_ovf_st, m_unf_st}) begin
                errors++; $display("FAIL rnd_sticky[%0d]: got %b want %b", j, {ovf_sticky, unf_sticky}, {m_ovf_st, m_unf_st}); end
        end
    endtask

    task automatic test_clr_midstream();
        do_reset();
        ops.push_back(mk(0,0,7'h00,7'h00,0,0,8'h7F,1,0));
        for (int i = 0; i < 6; i++) ops.push_back(mk(0,0,7'h40,7'h40,0,0,8'h7F,0,0));
        for (int i = 0; i < ops.size(); i++) vld.push_back(1'b1);
        for (int j = 0; j < 4; j++) begin drive_slot(j); @(negedge clk); end
        checks++; if (out_valid !== 1'b1 || ovf_sticky !== 1'b1) begin
            errors++; $display("FAIL clr_pre: got valid=%b ovf_sticky=%b want 1 1", out_valid, ovf_sticky); end
        drive_slot(4);
        #2 clr = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_valid_now: got %b want 0", out_valid); end
        checks++; if (product !== 16'h0000) begin errors++; $display("FAIL clr_product: got %h want 0000", product); end
        checks++; if ({ovf_out, unf_out, ovf_sticky, unf_sticky} !== 4'b0000) begin
            errors++; $display("FAIL clr_flags: got %b want 0000", {ovf_out, unf_out, ovf_sticky, unf_sticky}); end
        @(negedge clk);
        ops.delete(); vld.delete();
        drive_slot(0);
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_flushed[%0d]: got %b want 0", i, out_valid); end
        end
        // first operand after clr: valid exactly two edges after it is sampled
        ops.push_back(mk(0,0,7'h40,7'h40,0,0,8'h7F,0,0));
        vld.push_back(1'b1);
        drive_slot(0); @(negedge clk);
        drive_slot(1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_lat1: got %b want 0", out_valid); end
        @(negedge clk);
        drive_slot(2);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_lat2: got %b want 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || product !== 16'h4010) begin
            errors++; $display("FAIL clr_restart: got valid=%b product=%h want 1 4010", out_valid, product); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || product !== 16'h4010) begin
            errors++; $display("FAIL clr_hold: got valid=%b product=%h want 0 4010", out_valid, product); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_sticky();
        test_random();
        test_clr_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
